// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// The master drives operands and out_ready; the slave (the ALU) returns the result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, A, B, control, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, carry, overflow, negative
  );

  modport slave (
    input  in_valid, A, B, control, out_ready,
    output in_ready, out_valid, result, result_hi, zero, carry, overflow, negative
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, flags and a WIDTH-cycle shift-add multiply.
// Define ALU_SAT_EN to saturate ADD/SUB on signed overflow instead of wrapping.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic                 ovf_q, ovf_d, neg_q, neg_d;

  logic [WIDTH:0]       sum_w, diff_w, shl_w, shr_w, mul_sum;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic [2*WIDTH-1:0]   p_step;

  // Single-cycle ops evaluate straight from the bus and are captured on the accept edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shamt   = bus.B[SHW-1:0];
    sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
    diff_w  = {1'b0, bus.A} - {1'b0, bus.B};
    shl_w   = {1'b0, bus.A} << shamt;
    shr_w   = {bus.A, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(bus.control))
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction always follows the sign of A for both ADD and SUB.
    if (alu_v) alu_res = bus.A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // One multiplier bit per step: low half of p holds the remaining multiplier bits.
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    p_step  = {mul_sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (op_e'(bus.control) == OP_MUL) begin
            p_d     = {{WIDTH{1'b0}}, bus.B};
            mcand_d = bus.A;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            zero_d  = (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            neg_d   = alu_res[WIDTH-1];
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          res_d   = p_step[WIDTH-1:0];
          hi_d    = p_step[2*WIDTH-1:WIDTH];
          zero_d  = (p_step == '0);
          carry_d = |p_step[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          neg_d   = p_step[2*WIDTH-1];
          state_d = DONE;
        end
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  // in_ready is held low while reset is asserted so every output reads 0 in reset.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against an integer model.
module tb_alu_seq;
  localparam int     W    = 8;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         negative;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.in_ready  = bus.in_ready;
    o.out_valid = bus.out_valid;
    o.result    = bus.result;
    o.result_hi = bus.result_hi;
    o.zero      = bus.zero;
    o.carry     = bus.carry;
    o.overflow  = bus.overflow;
    o.negative  = bus.negative;
    return o;
  endfunction

  // Expected outputs while a result is being presented.
  function automatic obs_t mk(longint res, longint hi, logic z, logic c, logic v, logic n);
    obs_t o;
    o.in_ready  = 1'b0;
    o.out_valid = 1'b1;
    o.result    = W'(res);
    o.result_hi = W'(hi);
    o.zero      = z;
    o.carry     = c;
    o.overflow  = v;
    o.negative  = n;
    return o;
  endfunction

  // Reference: plain signed/unsigned integer arithmetic on the operand values.
  function automatic obs_t model(int op, longint a, longint b);
    longint res = 0, hi = 0, sa, sb, s, p;
    longint maxp = (longint'(1) << (W - 1)) - 1;
    longint minn = -(longint'(1) << (W - 1));
    logic   c = 1'b0, v = 1'b0;
    int     n;
    sa = (a > maxp) ? a - (MASK + 1) : a;
    sb = (b > maxp) ? b - (MASK + 1) : b;
    n  = int'(b % W);
    case (op)
      0, 1: begin
        s   = (op == 0) ? sa + sb : sa - sb;
        res = ((op == 0) ? a + b : a - b) & MASK;
        c   = (op == 0) ? ((a + b) > MASK) : (a < b);
        v   = (s > maxp) || (s < minn);
`ifdef ALU_SAT_EN
        if (v) res = (s > 0) ? maxp : (minn & MASK);
`endif
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin
        res = (a << n) & MASK;
        c   = (n != 0) && (((a >> (W - n)) & 1) != 0);
      end
      6: begin
        res = a >> n;
        c   = (n != 0) && (((a >> (n - 1)) & 1) != 0);
      end
      default: begin
        p   = a * b;
        res = p & MASK;
        hi  = p >> W;
        c   = (hi != 0);
      end
    endcase
    return mk(res, hi, (res == 0) && (hi == 0), c, v,
              (op == 7) ? (((hi >> (W - 1)) & 1) != 0) : (((res >> (W - 1)) & 1) != 0));
  endfunction

  // Present one op, then wait (bounded) for out_valid; lat counts edges from the accept edge.
  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output obs_t got);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.A = a; bus.B = b; bus.control = 3'(op); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.control = 3'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    got = sample();
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    got = sample();
    n_checks++;
    if (got !== obs_t'('0)) $display("FAIL reset_outputs: got %h expected %h", got, obs_t'('0));
    else n_pass++;
    #11 rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL reset_release: in_ready/out_valid got %b expected 10", {bus.in_ready, bus.out_valid});
    else n_pass++;
  endtask

  task automatic test_add();
    obs_t got, exp;
    int   lat;
    bus.out_ready = 1'b1;
    run_op(0, 8'd200, 8'd100, lat, got);
    exp = mk(44, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (got !== exp) $display("FAIL add_200_100: got %h expected %h", got, exp);
    else n_pass++;
    n_checks++;
    if (lat !== 1) $display("FAIL add_latency: got %0d expected 1", lat);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL add_deliver: out_valid/in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
  endtask

  task automatic test_sub();
    obs_t got, exp;
    int   lat;
    run_op(1, 8'd5, 8'd5, lat, got);
    exp = mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (got !== exp) $display("FAIL sub_5_5: got %h expected %h", got, exp);
    else n_pass++;
    @(posedge clk); #1;
    run_op(1, 8'd3, 8'd5, lat, got);
    exp = mk(8'hFE, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (got !== exp) $display("FAIL sub_3_5: got %h expected %h", got, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    obs_t got, exp;
    int   lat;
    run_op(0, 8'h7F, 8'h01, lat, got);
`ifdef ALU_SAT_EN
    exp = mk(8'h7F, 0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    exp = mk(8'h80, 0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    n_checks++;
    if (got !== exp) $display("FAIL add_overflow: got %h expected %h", got, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    obs_t got, exp;
    int   lat   = 1;
    int   guard = 0;
    logic bad   = 1'b0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.A = 8'hFF; bus.B = 8'hFF; bus.control = 3'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep offering junk while busy; none of it may be accepted or disturb the product.
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) bad = 1'b1;
      bus.in_valid = 1'b1; bus.A = W'($urandom); bus.B = W'($urandom); bus.control = 3'($urandom);
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    got = sample();
    exp = mk(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (got !== exp) $display("FAIL mul_ff_ff: got %h expected %h", got, exp);
    else n_pass++;
    n_checks++;
    if (lat !== W + 1) $display("FAIL mul_latency: got %0d expected %0d", lat, W + 1);
    else n_pass++;
    n_checks++;
    if (bad !== 1'b0) $display("FAIL mul_busy_ready: in_ready seen high during BUSY");
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL mul_deliver: out_valid/in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    obs_t got, exp, held;
    int   lat;
    logic unstable = 1'b0;
    bus.out_ready = 1'b0;
    run_op(5, 8'h81, 8'd1, lat, got);
    exp = mk(8'h02, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (got !== exp) $display("FAIL shl_81_1: got %h expected %h", got, exp);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      held = sample();
      if (held !== exp) unstable = 1'b1;
    end
    n_checks++;
    if (unstable !== 1'b0) $display("FAIL stall_hold: got %h expected %h", held, exp);
    else n_pass++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL stall_release: out_valid/in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    obs_t got, exp;
    int   lat;
    bus.A = 8'hFF; bus.B = 8'hFF; bus.control = 3'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== obs_t'('0)) $display("FAIL abort_outputs: got %h expected %h", got, obs_t'('0));
    else n_pass++;
    #2 rst_n = 1'b1;
    #2;
    n_checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL abort_release: in_ready/out_valid got %b expected 10", {bus.in_ready, bus.out_valid});
    else n_pass++;
    run_op(0, 8'd1, 8'd1, lat, got);
    exp = mk(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (got !== exp) $display("FAIL abort_then_add: got %h expected %h", got, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    obs_t         got, exp;
    int           lat, op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      run_op(op, a, b, lat, got);
      exp = model(op, longint'(a), longint'(b));
      n_checks++;
      if (got !== exp) $display("FAIL rand_op%0d a=%h b=%h: got %h expected %h", op, a, b, got, exp);
      else n_pass++;
      n_checks++;
      if (lat !== ((op == 7) ? W + 1 : 1)) $display("FAIL rand_latency op%0d: got %0d", op, lat);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.control   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor of the team's 8-bit combinational ALU. Adds a valid/ready handshake on input and output, registered results, a full flag set (zero, carry, overflow, negative) and a multi-cycle shift-add multiply. Sits between the operand source and the writeback or consumer stage, so ALU latency never sits on a combinational path.

Parameters:
WIDTH, 8, operand/result width; must be a power of two, >= 4.
SHW, $clog2(WIDTH), derived shift-amount width (localparam, not user-set).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept an operation
A  input  WIDTH  operand A
B  input  WIDTH  operand B
control  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  result (MUL: low half of product)
result_hi  output  WIDTH  MUL high half; 0 for all other ops
zero  output  1  result (and result_hi for MUL) all zero
carry  output  1  carry/borrow/shift-out, see below
overflow  output  1  signed overflow (ADD/SUB only)
negative  output  1  MSB of result (MUL: MSB of result_hi)

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, except in_ready = 1 once rst_n is high. Reset mid-operation aborts it with no output.
- FSM states: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE.
- Accept when in_valid && in_ready. A, B and control are latched; input changes after acceptance are ignored.
- IDLE -> DONE for ops 0-6. The result is registered on the accept edge, so out_valid rises 1 cycle after accept.
- IDLE -> BUSY for MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY. BUSY -> DONE after the last step; out_valid rises WIDTH+1 cycles after accept.
- DONE: out_valid = 1. All outputs hold stable until out_ready. On out_valid && out_ready go to IDLE and drop out_valid the next cycle.
- Throughput: one single-cycle op every 2 cycles at most (accept, deliver).
- ADD: WIDTH-bit wrap. carry = unsigned carry-out. overflow = operands share a sign and the result sign differs.
- SUB: A-B wrap. carry = borrow (A < B unsigned). overflow = signs of A and B differ and the result sign differs from A.
- AND/OR/XOR: carry = 0, overflow = 0.
- SHL/SHR: shift amount n = B[SHW-1:0]; zero fill. carry = last bit shifted out (SHL: A[WIDTH-n]; SHR: A[n-1]); n = 0 gives result = A, carry = 0. overflow = 0.
- MUL: {result_hi, result} = A*B unsigned. carry = (result_hi != 0). overflow = 0.
- result_hi = 0 for every op except MUL.
- zero and negative are computed from the final registered value.

Optional Feature:
ALU_SAT_EN
- Defined: ADD/SUB saturate on signed overflow. Positive overflow gives 0 followed by ones (8-bit: 0x7F); negative overflow gives 1 followed by zeros (0x80). overflow is still set; carry is unchanged; zero and negative follow the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH as described in Behaviour.

Test Plan (WIDTH=8):
1. ADD A=200, B=100, out_ready=1 -> result=44, carry=1, overflow=0, zero=0. out_valid 1 cycle after accept; in_ready high again the cycle after delivery.
2. SUB A=5, B=5 -> result=0, zero=1, carry=0. Then SUB A=3, B=5 -> result=0xFE, carry=1, negative=1.
3. ADD A=0x7F, B=0x01 -> result=0x80, overflow=1. Rebuilt with ALU_SAT_EN -> result=0x7F, overflow=1.
4. MUL A=0xFF, B=0xFF -> result_hi=0xFE, result=0x01, carry=1. out_valid exactly 9 cycles after accept; in_ready=0 throughout BUSY; input changes during BUSY have no effect.
5. SHL A=0x81, B=1 -> result=0x02, carry=1. With out_ready held 0 for 5 cycles: outputs stable, in_ready=0; out_ready=1 -> delivered, then IDLE.
6. Pulse rst_n low at the 4th BUSY cycle of a MUL -> all outputs 0 immediately; after release in_ready=1; a following ADD 1+1 -> result=2.
